port_alloc: RTL and testbench
=============================

Name: port_alloc

Overview:
- Per-cycle output-port allocator for the 5-channel bufferless deflection router (channels 4-Bypass, 3-N, 2-S, 1-E, 0-W).
- Takes per-input valid and productive-port masks and assigns every valid input exactly one distinct output port.
- Productive ports are granted where free; otherwise the input is deflected.
- Produces the registered allocation matrix consumed directly by the crossbar control stage (one-hot row per input).

Parameters:
- NUM_CHANNEL, 5, number of input/output channels.
- LOG_NUM_PORT, 3, width of a port index.
- CNT_W, 16, width of each deflection counter (optional feature only).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all registered state and outputs this cycle.
- req_valid  input  NUM_CHANNEL  bit j: flit present on input j.
- prod_vec  input  NUM_CHANNEL*NUM_CHANNEL  bits [j*NUM_CHANNEL+:NUM_CHANNEL]: productive output mask for input j.
- alloc_vector  output  NUM_CHANNEL*NUM_CHANNEL  bits [j*NUM_CHANNEL+:NUM_CHANNEL]: one-hot output grant for input j, all-zero if no grant.
- alloc_valid  output  NUM_CHANNEL  bit j: row j of alloc_vector is valid.
- deflected  output  NUM_CHANNEL  bit j: input j was granted a non-productive port.
- prio_ptr  output  LOG_NUM_PORT  current highest-priority input index.
- defl_count  output  NUM_CHANNEL*CNT_W  per-input deflection counters; present only with DEFLECT_STAT_EN.

Behaviour:
- Reset (async, rst_n=0): alloc_vector=0, alloc_valid=0, deflected=0, prio_ptr=0, defl_count=0.
- Latency: inputs sampled at rising clk; results appear on outputs one cycle later. Registered outputs only; no combinational input-to-output path.
- Allocation order, combinational within the cycle:
  - Inputs are visited in order prio_ptr, prio_ptr+1, ... modulo NUM_CHANNEL.
  - Each valid input takes the lowest-index free port in (prod_vec row AND free mask).
  - If that set is empty, the input takes the lowest-index free port of any kind and its deflected bit is set.
  - Granted ports are removed from the free mask before the next input is visited.
  - An invalid input gets a zero row, alloc_valid=0, deflected=0.
  - A valid input with an all-zero prod_vec row is treated as deflected.
- Invariant: popcount(req_valid) <= NUM_CHANNEL, so every valid input always receives a port. Output columns of alloc_vector are mutually exclusive (at most one 1 per column).
- Priority pointer:
  - On a non-stalled clock with |req_valid=1, prio_ptr <= (prio_ptr==NUM_CHANNEL-1) ? 0 : prio_ptr+1.
  - With no valid requests, prio_ptr is unchanged.
- stall=1: all registers hold, including prio_ptr and counters. req_valid and prod_vec are ignored that cycle; the caller re-presents requests.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The first allocation after release uses prio_ptr=0.
- Unused state: none. There is no FSM beyond the rotating pointer and pipeline register.

Optional Feature:
- PORT_ALLOC_DEFLECT_STAT_EN defined:
  - Per-input saturating counter of CNT_W bits.
  - Increments on each non-stalled cycle where input j is deflected; holds at all-ones.
  - Cleared by reset; driven on defl_count.
- PORT_ALLOC_DEFLECT_STAT_EN not defined:
  - No counters and no defl_count port.
  - All other behaviour is identical.

Decomposition:
- Shared package: NUM_CHANNEL, LOG_NUM_PORT, and port index constants PORT_W=0, PORT_E=1, PORT_S=2, PORT_N=3, PORT_BYPASS=4.
- One sub-module, port_alloc_pick: combinational lowest-index one-hot picker (mask in -> one-hot out plus any-bit flag). It is instantiated twice per visited input (productive pick and fallback pick).

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0 and prio_ptr=0. Release rst_n -> first result appears one cycle after the first sampled request.
- No conflict, prio_ptr=0: req_valid=00011, prod row0=00010, row1=00001 -> row0=00010, row1=00001, deflected=0, prio_ptr becomes 1.
- Conflict with rotation: all five valid, every prod row=01000, prio_ptr=2 -> input2 gets 01000 and is not deflected. Inputs 3,4,0,1 get 00001, 00010, 00100, 10000 respectively, all deflected.
- Stall: stall=1 for 3 cycles with changing requests -> outputs and prio_ptr unchanged. The cycle after stall drops, outputs reflect the newly sampled requests.
- Pointer wrap and idle: prio_ptr=4 with a valid request -> 0 next cycle. A cycle with req_valid=0 -> pointer unchanged, alloc_valid=0.
- With PORT_ALLOC_DEFLECT_STAT_EN and CNT_W=2: force input0 deflected for 5 cycles -> defl_count[0] steps 1, 2, 3, 3, 3; other counters stay 0.

Source files
------------

// File: rtl/port_alloc_pkg.sv
// -----------------------------------------------------------------------------
// port_alloc_pkg
// Shared constants for the deflection-router output-port allocator.
//   NUM_CHANNEL  : number of router channels (inputs == outputs)
//   LOG_NUM_PORT : width of a port / input index
//   PORT_*       : output port indices (W=0, E=1, S=2, N=3, Bypass=4)
// -----------------------------------------------------------------------------
package port_alloc_pkg;

  localparam int NUM_CHANNEL  = 5;
  localparam int LOG_NUM_PORT = 3;

  localparam logic [LOG_NUM_PORT-1:0] PORT_W      = 3'd0;
  localparam logic [LOG_NUM_PORT-1:0] PORT_E      = 3'd1;
  localparam logic [LOG_NUM_PORT-1:0] PORT_S      = 3'd2;
  localparam logic [LOG_NUM_PORT-1:0] PORT_N      = 3'd3;
  localparam logic [LOG_NUM_PORT-1:0] PORT_BYPASS = 3'd4;

  // Rotating-pointer advance for the default channel count: the bypass
  // channel is the last index, after which the pointer wraps to west.
  function automatic logic [LOG_NUM_PORT-1:0] ptr_inc(input logic [LOG_NUM_PORT-1:0] p);
    return (p == PORT_BYPASS) ? PORT_W : p + 1'b1;
  endfunction

endpackage

// File: rtl/port_alloc_pick.sv
// -----------------------------------------------------------------------------
// port_alloc_pick
// Combinational lowest-index picker.
//   mask_i   : candidate bit mask
//   onehot_o : one-hot of the lowest set bit of mask_i (zero if mask_i == 0)
//   any_o    : 1 when mask_i has any bit set
// -----------------------------------------------------------------------------
module port_alloc_pick #(
  parameter int W = port_alloc_pkg::NUM_CHANNEL
) (
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] onehot_o,
  output logic         any_o
);
  import port_alloc_pkg::*;

  // Two's-complement trick: m & -m isolates the lowest set bit.
  assign onehot_o = mask_i & (~mask_i + W'(1));
  assign any_o    = |mask_i;

endmodule

// File: rtl/port_alloc.sv
// -----------------------------------------------------------------------------
// port_alloc
// Per-cycle output-port allocator for a 5-channel bufferless deflection
// router. Every valid input receives exactly one distinct output port:
// a free productive port when possible, otherwise any free port (deflection).
// Inputs are served in rotating order starting at prio_ptr. All outputs are
// registered (one cycle latency); stall holds every register.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : hold all state; requests ignored this cycle
//   req_valid     : bit j = flit present on input j
//   prod_vec      : row j = productive output mask of input j
//   alloc_vector  : row j = one-hot output grant of input j (zero if none)
//   alloc_valid   : bit j = row j valid
//   deflected     : bit j = input j was given a non-productive port
//   prio_ptr      : current highest-priority input
//   defl_count    : per-input saturating deflection counters
//                   (only when PORT_ALLOC_DEFLECT_STAT_EN is defined)
// -----------------------------------------------------------------------------
module port_alloc #(
  parameter int NUM_CHANNEL  = port_alloc_pkg::NUM_CHANNEL,
  parameter int LOG_NUM_PORT = port_alloc_pkg::LOG_NUM_PORT,
  parameter int CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic [NUM_CHANNEL-1:0]           req_valid,
  input  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] prod_vec,
  output logic [NUM_CHANNEL*NUM_CHANNEL-1:0] alloc_vector,
  output logic [NUM_CHANNEL-1:0]           alloc_valid,
  output logic [NUM_CHANNEL-1:0]           deflected,
  output logic [LOG_NUM_PORT-1:0]          prio_ptr
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
  ,
  output logic [NUM_CHANNEL*CNT_W-1:0]     defl_count
`endif
);
  import port_alloc_pkg::*;

  localparam logic [LOG_NUM_PORT:0]   N_EXT    = (LOG_NUM_PORT+1)'(NUM_CHANNEL);
  localparam logic [LOG_NUM_PORT-1:0] LAST_IDX = LOG_NUM_PORT'(NUM_CHANNEL-1);

  // Registered state
  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] alloc_q;
  logic [NUM_CHANNEL-1:0]             valid_q;
  logic [NUM_CHANNEL-1:0]             defl_q;
  logic [LOG_NUM_PORT-1:0]            prio_q;

  // Next-state values
  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] alloc_d;
  logic [NUM_CHANNEL-1:0]             valid_d;
  logic [NUM_CHANNEL-1:0]             defl_d;
  logic [LOG_NUM_PORT-1:0]            prio_d;

  // Per-visit-step signals. Step k serves input (prio_q + k) mod NUM_CHANNEL;
  // free_mask[k] is the set of ports still unclaimed when step k runs.
  logic [NUM_CHANNEL-1:0]  free_mask  [NUM_CHANNEL+1];
  logic [LOG_NUM_PORT-1:0] step_idx   [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0]  step_grant [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0]  step_defl;

  assign free_mask[0] = '1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_step
      logic [LOG_NUM_PORT:0]  idx_sum;
      logic [NUM_CHANNEL-1:0] prod_row;
      logic                   step_req;
      logic [NUM_CHANNEL-1:0] prod_oh;
      logic [NUM_CHANNEL-1:0] fb_oh;
      logic                   prod_any;
      logic                   fb_any;

      // Modulo without a divider: the sum never reaches 2*NUM_CHANNEL.
      assign idx_sum      = {1'b0, prio_q} + (LOG_NUM_PORT+1)'(gi);
      assign step_idx[gi] = (idx_sum >= N_EXT) ? LOG_NUM_PORT'(idx_sum - N_EXT)
                                               : LOG_NUM_PORT'(idx_sum);

      assign prod_row = prod_vec[step_idx[gi]*NUM_CHANNEL +: NUM_CHANNEL];
      assign step_req = req_valid[step_idx[gi]];

      port_alloc_pick #(.W(NUM_CHANNEL)) u_pick_prod (
        .mask_i   (prod_row & free_mask[gi]),
        .onehot_o (prod_oh),
        .any_o    (prod_any)
      );

      port_alloc_pick #(.W(NUM_CHANNEL)) u_pick_fb (
        .mask_i   (free_mask[gi]),
        .onehot_o (fb_oh),
        .any_o    (fb_any)
      );

      // fb_any is only ever low when more inputs are valid than ports exist,
      // which the router never presents; the grant is then simply empty.
      assign step_grant[gi] = !step_req ? '0 :
                              prod_any  ? prod_oh :
                              fb_any    ? fb_oh : '0;
      // An all-zero productive row also lands here as a deflection.
      assign step_defl[gi]  = step_req & ~prod_any;

      assign free_mask[gi+1] = free_mask[gi] & ~step_grant[gi];
    end
  endgenerate

  // Scatter per-step results back to per-input rows. step_idx is a
  // permutation of 0..NUM_CHANNEL-1, so every row is written exactly once.
  always_comb begin
    alloc_d = '0;
    valid_d = '0;
    defl_d  = '0;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      alloc_d[step_idx[k]*NUM_CHANNEL +: NUM_CHANNEL] = step_grant[k];
      valid_d[step_idx[k]] = |step_grant[k];
      defl_d[step_idx[k]]  = step_defl[k];
    end
  end

  assign prio_d = (prio_q == LAST_IDX) ? '0 : prio_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      valid_q <= '0;
      defl_q  <= '0;
      prio_q  <= '0;
    end else if (!stall) begin
      alloc_q <= alloc_d;
      valid_q <= valid_d;
      defl_q  <= defl_d;
      // The pointer only rotates when somebody was actually served.
      if (|req_valid) begin
        prio_q <= prio_d;
      end
    end
  end

  assign alloc_vector = alloc_q;
  assign alloc_valid  = valid_q;
  assign deflected    = defl_q;
  assign prio_ptr     = prio_q;

`ifdef PORT_ALLOC_DEFLECT_STAT_EN
  generate
    for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      // Saturating: once all-ones the counter sticks until reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (!stall && defl_d[gi] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign defl_count[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_port_alloc.sv
// -----------------------------------------------------------------------------
// tb_port_alloc
// Scoreboard bench for port_alloc. The driver pushes the reference model's
// expected registered outputs every clock; a separate monitor pops and
// compares them. Directed cases from the allocation rules are also checked
// against literal constants. Build with PORT_ALLOC_DEFLECT_STAT_EN to cover
// the deflection counters (CNT_W=2).
// -----------------------------------------------------------------------------
module tb_port_alloc;

  localparam int N  = 5;
  localparam int LP = 3;
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*N-1:0]   prod_vec = '0;
  logic [N*N-1:0]   alloc_vector;
  logic [N-1:0]     alloc_valid;
  logic [N-1:0]     deflected;
  logic [LP-1:0]    prio_ptr;
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
  logic [N*CW-1:0]  defl_count;
`endif

  port_alloc #(.NUM_CHANNEL(N), .LOG_NUM_PORT(LP), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .req_valid    (req_valid),
    .prod_vec     (prod_vec),
    .alloc_vector (alloc_vector),
    .alloc_valid  (alloc_valid),
    .deflected    (deflected),
    .prio_ptr     (prio_ptr)
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
    ,
    .defl_count   (defl_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*N-1:0]  alloc;
    logic [N-1:0]    vld;
    logic [N-1:0]    defl;
    logic [LP-1:0]   prio;
    logic [N*CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m = '0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: serve inputs in rotating order; each takes the lowest
  // free productive port, else the lowest free port of any kind.
  function automatic exp_t model_next(input exp_t cur);
    exp_t       nxt;
    logic [N-1:0] free;
    int         j, port, cmax;
    if (!rst_n) return '0;
    if (stall) return cur;
    nxt       = cur;
    nxt.alloc = '0;
    nxt.vld   = '0;
    nxt.defl  = '0;
    free      = '1;
    for (int k = 0; k < N; k++) begin
      j = (int'(cur.prio) + k) % N;
      if (req_valid[j]) begin
        port = -1;
        for (int p = 0; p < N; p++)
          if (port < 0 && prod_vec[j*N+p] && free[p]) port = p;
        if (port < 0) begin
          nxt.defl[j] = 1'b1;
          for (int p = 0; p < N; p++)
            if (port < 0 && free[p]) port = p;
        end
        if (port >= 0) begin
          nxt.alloc[j*N+port] = 1'b1;
          free[port]          = 1'b0;
          nxt.vld[j]          = 1'b1;
        end
      end
    end
    if (req_valid != '0) nxt.prio = LP'((int'(cur.prio) + 1) % N);
    cmax = (1 << CW) - 1;
    for (int c = 0; c < N; c++)
      if (nxt.defl[c] && int'(cur.cnt[c*CW +: CW]) < cmax)
        nxt.cnt[c*CW +: CW] = cur.cnt[c*CW +: CW] + CW'(1);
    return nxt;
  endfunction

  // Drive one cycle of stimulus; after return the DUT outputs reflect it.
  task automatic cycle(input logic s, input logic [N-1:0] v, input logic [N*N-1:0] p);
    stall     = s;
    req_valid = v;
    prod_vec  = p;
    @(posedge clk);
    m = model_next(m);
    exp_q.push_back(m);
    #1;
  endtask

  function automatic logic [N*N-1:0] rand_prod();
    logic [N*N-1:0] r;
    for (int j = 0; j < N; j++)
      r[j*N +: N] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_alloc"}, 128'(alloc_vector), 128'(0));
    chk({tag, "_valid"}, 128'(alloc_valid), 128'(0));
    chk({tag, "_defl"},  128'(deflected), 128'(0));
    chk({tag, "_prio"},  128'(prio_ptr), 128'(0));
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
    chk({tag, "_cnt"},   128'(defl_count), 128'(0));
`endif
  endtask

  // Async reset in the middle of a cycle, after the monitor has sampled.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    cycle(1'b0, N'($urandom), rand_prod());
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the scoreboard once per clock.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_alloc", 128'(alloc_vector), 128'(e.alloc));
        chk("sb_valid", 128'(alloc_valid), 128'(e.vld));
        chk("sb_defl",  128'(deflected), 128'(e.defl));
        chk("sb_prio",  128'(prio_ptr), 128'(e.prio));
`ifdef PORT_ALLOC_DEFLECT_STAT_EN
        chk("sb_cnt",   128'(defl_count), 128'(e.cnt));
`endif
        $display("cycle t=%0t valid=%b alloc=%h defl=%b prio=%0d",
                 $time, alloc_valid, alloc_vector, deflected, prio_ptr);
      end
    end
  end

  localparam logic [N*N-1:0] CONFLICT_EXP =
    {5'b00010, 5'b00001, 5'b01000, 5'b10000, 5'b00100};

  initial begin : driver
    // Reset held with random inputs
    repeat (3) cycle(1'b0, N'($urandom), rand_prod());
    check_zero("reset");
    rst_n = 1'b1;

    // No conflict from prio 0
    cycle(1'b0, 5'b00011, {5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00010});
    chk("nc_alloc", 128'(alloc_vector), 128'({5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00010}));
    chk("nc_defl",  128'(deflected), 128'(5'b00000));
    chk("nc_prio",  128'(prio_ptr), 128'(1));

    // Advance pointer to 2, then full conflict on port N
    cycle(1'b0, 5'b00001, '1);
    cycle(1'b0, 5'b11111, {5{5'b01000}});
    chk("cf_alloc", 128'(alloc_vector), 128'(CONFLICT_EXP));
    chk("cf_defl",  128'(deflected), 128'(5'b11011));
    chk("cf_valid", 128'(alloc_valid), 128'(5'b11111));
    chk("cf_prio",  128'(prio_ptr), 128'(3));

    // Stall three cycles with changing requests
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, N'($urandom), rand_prod());
      chk($sformatf("stall%0d_alloc", i), 128'(alloc_vector), 128'(CONFLICT_EXP));
      chk($sformatf("stall%0d_prio", i),  128'(prio_ptr), 128'(3));
    end

    // Stall drops: input 4 to port S, pointer 3 -> 4
    cycle(1'b0, 5'b10000, {5'b00100, 20'b0});
    chk("post_stall_alloc", 128'(alloc_vector), 128'({5'b00100, 20'b0}));
    chk("post_stall_prio",  128'(prio_ptr), 128'(4));

    // Wrap 4 -> 0
    cycle(1'b0, 5'b00100, {10'b0, 5'b00001, 10'b0});
    chk("wrap_prio", 128'(prio_ptr), 128'(0));

    // Idle: pointer holds, nothing valid
    cycle(1'b0, 5'b00000, rand_prod());
    chk("idle_prio",  128'(prio_ptr), 128'(0));
    chk("idle_valid", 128'(alloc_valid), 128'(0));

    async_reset();

`ifdef PORT_ALLOC_DEFLECT_STAT_EN
    // Input 0 with empty productive row: deflected every cycle
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 5'b00001, '0);
      chk($sformatf("cnt0_step%0d", i), 128'(defl_count[CW-1:0]), 128'((i < 3) ? i + 1 : 3));
      chk($sformatf("cnt_rest_step%0d", i), 128'(defl_count[N*CW-1:CW]), 128'(0));
    end
`endif

    // Randomised traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) == 0), N'($urandom), rand_prod());
      if (i == 200) async_reset();
    end

    stall     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
